setup_confirm_tx: RTL and testbench
===================================

SETUP_CONFIRM_TX -- requirements
Module: setup_confirm_tx

Interface
REQ-001 SHALL have parameter SRC_X, default -1, NoC x-coordinate of this tile.
REQ-002 SHALL have parameter SRC_Y, default -1, NoC y-coordinate of this tile.
REQ-003 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, synchronous active-high reset), listed first.
REQ-004 SHALL have ports cmd_q_val (in, 1), cmd_q_data (in, send_q_struct), cmd_q_rdy (out, 1): confirm commands from the send loop queue.
REQ-005 SHALL have ports confirm_ptr_noc_val (out, 1), confirm_ptr_noc_data (out, NOC_DATA_WIDTH), ptr_noc_confirm_rdy (in, 1): pointer request flits to the TCP TX tile.
REQ-006 SHALL have ports ptr_noc_confirm_val (in, 1), ptr_noc_confirm_data (in, NOC_DATA_WIDTH), confirm_ptr_noc_rdy (out, 1): pointer response flits.
REQ-007 SHALL have ports confirm_wr_buf_req_val (out, 1), confirm_wr_buf_req_flowid (out, FLOWID_W), confirm_wr_buf_req_offset (out, TX_PAYLOAD_PTR_W), confirm_wr_buf_req_size (out, MSG_DATA_SIZE_WIDTH), wr_buf_confirm_req_rdy (in, 1).
REQ-008 SHALL have ports confirm_wr_buf_data_val (out, 1), confirm_wr_buf_data (out, NOC_DATA_WIDTH), wr_buf_confirm_data_rdy (in, 1), wr_buf_confirm_done_val (in, 1), confirm_wr_buf_done_rdy (out, 1).
REQ-009 SHALL have ports confirm_sent_val (out, 1) and confirm_sent_flowid (out, FLOWID_W): completion pulse.

Function
REQ-010 SHALL implement FSM states IDLE, PTR_REQ, PTR_RESP, WR_REQ, WR_DATA, WR_DONE, PTR_ADJ.
REQ-011 IDLE: cmd_q_rdy=1; on cmd_q_val with cmd==CTRL_RESP SHALL latch flowid and go PTR_REQ; cmd==BENCH SHALL be consumed and dropped, staying IDLE.
REQ-012 PTR_REQ: SHALL drive header flit, msg_type TCP_TX_MSG_REQ, dst TCP_TX_TILE_X/Y, dst_fbits TCP_TX_APP_PTR_IF_FBITS, src SRC_X/SRC_Y/SETUP_IF_FBITS, msg_len 0, inner.flowid=latched flowid, inner.length=CONFIRM_BYTES; advance on val&rdy.
REQ-013 PTR_RESP: confirm_ptr_noc_rdy=1; on val SHALL latch inner.head_ptr; if inner.length >= CONFIRM_BYTES go WR_REQ, else return to PTR_REQ (retry, no limit).
REQ-014 WR_REQ: flowid=latched, offset=head_ptr[TX_PAYLOAD_PTR_W-1:0], size=CONFIRM_BYTES; advance on val&rdy.
REQ-015 WR_DATA: single flit; data = latched flowid zero-extended into the most-significant FLOWID_W bits, all other bits 0; advance on val&rdy.
REQ-016 WR_DONE: confirm_wr_buf_done_rdy=1; advance on done_val.
REQ-017 PTR_ADJ: flit as REQ-012 but msg_type TCP_TX_ADJUST_PTR, inner.head_ptr = latched head_ptr + CONFIRM_BYTES truncated to pointer width (natural wrap); on val&rdy SHALL pulse confirm_sent_val one cycle with flowid, return IDLE.
REQ-018 All val outputs SHALL be held stable with data unchanged until rdy; no output SHALL depend combinationally on its own rdy.
REQ-019 Only one command in flight; cmd_q_rdy=0 outside IDLE.
REQ-020 Pointer offset wrap: head_ptr near buffer end SHALL still issue one request at its low-bit offset; wr-buf module handles wrap.

Reset
REQ-021 rst SHALL force IDLE, all val outputs 0, confirm_sent_val 0, latched flowid/head_ptr 0, in the cycle after assertion.
REQ-022 rst mid-transaction SHALL abandon the transaction without completion pulse.

Structure
REQ-023 CONFIRM_BYTES (≤ NOC_DATA_BYTES) and the FSM state enum SHALL live in setup_open_loop_pkg.
REQ-024 SHALL split into setup_confirm_tx_ctrl (FSM) and setup_confirm_tx_datap (registers, flit build).

Verification
REQ-025 CTRL_RESP flowid 5, response length 64, head_ptr 0x10 -> wr offset 0x10, adjust head_ptr 0x10+CONFIRM_BYTES, one confirm_sent pulse flowid 5.
REQ-026 Response length 0 then 64 -> exactly two TCP_TX_MSG_REQ flits, one write, one adjust.
REQ-027 BENCH command -> consumed in one cycle, no NoC or buffer traffic.
REQ-028 rdy held low 10 cycles in each handshake state -> val/data stable, no state advance.
REQ-029 head_ptr all-ones minus 1 -> adjust pointer wraps modulo pointer width.
REQ-030 rst asserted in WR_DATA -> next cycle IDLE, all val 0, no completion pulse.

Source files
------------

// File: rtl/setup_open_loop_pkg.sv
// Shared types and constants for the setup open-loop tiles: NoC flit layout,
// send-queue command format and the confirm-TX state encoding.
package setup_open_loop_pkg;

  localparam int unsigned NOC_DATA_WIDTH      = 256;
  localparam int unsigned NOC_DATA_BYTES      = NOC_DATA_WIDTH / 8;
  localparam int unsigned XY_W                = 8;
  localparam int unsigned FBITS_W             = 4;
  localparam int unsigned MSG_LEN_W           = 8;
  localparam int unsigned MSG_TYPE_W          = 8;
  localparam int unsigned FLOWID_W            = 8;
  localparam int unsigned MSG_DATA_SIZE_WIDTH = 16;
  localparam int unsigned TX_PAYLOAD_PTR_W    = 12;
  // Extra top bit distinguishes a full ring from an empty one.
  localparam int unsigned PAYLOAD_PTR_W       = TX_PAYLOAD_PTR_W + 1;

  // Must not exceed NOC_DATA_BYTES: the confirm message fits in one data flit.
  localparam int unsigned CONFIRM_BYTES       = 8;

  localparam logic [MSG_TYPE_W-1:0] TCP_TX_MSG_REQ    = 8'd10;
  localparam logic [MSG_TYPE_W-1:0] TCP_TX_ADJUST_PTR = 8'd11;

  localparam logic [XY_W-1:0]    TCP_TX_TILE_X           = 8'd1;
  localparam logic [XY_W-1:0]    TCP_TX_TILE_Y           = 8'd0;
  localparam logic [FBITS_W-1:0] TCP_TX_APP_PTR_IF_FBITS = 4'd2;
  localparam logic [FBITS_W-1:0] SETUP_IF_FBITS          = 4'd3;

  localparam logic [1:0] CTRL_RESP = 2'd1;
  localparam logic [1:0] BENCH     = 2'd2;

  typedef struct packed {
    logic [1:0]          cmd;
    logic [FLOWID_W-1:0] flowid;
  } send_q_struct;

  typedef struct packed {
    logic [XY_W-1:0]       dst_x;
    logic [XY_W-1:0]       dst_y;
    logic [FBITS_W-1:0]    dst_fbits;
    logic [MSG_LEN_W-1:0]  msg_len;
    logic [MSG_TYPE_W-1:0] msg_type;
    logic [XY_W-1:0]       src_x;
    logic [XY_W-1:0]       src_y;
    logic [FBITS_W-1:0]    src_fbits;
  } noc_hdr_t;

  typedef struct packed {
    logic [FLOWID_W-1:0]            flowid;
    logic [MSG_DATA_SIZE_WIDTH-1:0] length;
    logic [PAYLOAD_PTR_W-1:0]       head_ptr;
  } tcp_ptr_inner_t;

  localparam int unsigned FLIT_PAD_W = NOC_DATA_WIDTH - $bits(noc_hdr_t) - $bits(tcp_ptr_inner_t);

  typedef struct packed {
    noc_hdr_t                hdr;
    tcp_ptr_inner_t          inner;
    logic [FLIT_PAD_W-1:0]   pad;
  } ptr_flit_t;

  typedef enum logic [2:0] {
    StIdle,
    StPtrReq,
    StPtrResp,
    StWrReq,
    StWrData,
    StWrDone,
    StPtrAdj
  } confirm_state_e;

endpackage

// File: rtl/setup_confirm_tx_ctrl.sv
// Sequencing FSM for one confirm: pointer request, buffer write, pointer adjust.
module setup_confirm_tx_ctrl
  import setup_open_loop_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cmd_val_i,
  input  logic cmd_is_resp_i,
  input  logic ptr_req_rdy_i,
  input  logic ptr_resp_val_i,
  input  logic resp_len_ok_i,
  input  logic wr_req_rdy_i,
  input  logic wr_data_rdy_i,
  input  logic done_val_i,
  output logic cmd_rdy_o,
  output logic ptr_req_val_o,
  output logic ptr_resp_rdy_o,
  output logic wr_req_val_o,
  output logic wr_data_val_o,
  output logic done_rdy_o,
  output logic latch_flowid_o,
  output logic latch_ptr_o,
  output logic adj_sel_o,
  output logic sent_set_o
);

  confirm_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (cmd_val_i && cmd_is_resp_i) state_d = StPtrReq;
      StPtrReq:  if (ptr_req_rdy_i) state_d = StPtrResp;
      StPtrResp: if (ptr_resp_val_i) state_d = resp_len_ok_i ? StWrReq : StPtrReq;
      StWrReq:   if (wr_req_rdy_i) state_d = StWrData;
      StWrData:  if (wr_data_rdy_i) state_d = StWrDone;
      StWrDone:  if (done_val_i) state_d = StPtrAdj;
      StPtrAdj:  if (ptr_req_rdy_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Valids come from state only, so they never depend on their own ready.
  always_comb begin
    cmd_rdy_o      = 1'b0;
    ptr_req_val_o  = 1'b0;
    ptr_resp_rdy_o = 1'b0;
    wr_req_val_o   = 1'b0;
    wr_data_val_o  = 1'b0;
    done_rdy_o     = 1'b0;
    latch_flowid_o = 1'b0;
    latch_ptr_o    = 1'b0;
    adj_sel_o      = 1'b0;
    sent_set_o     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_rdy_o      = 1'b1;
        latch_flowid_o = cmd_val_i && cmd_is_resp_i;
      end
      StPtrReq:  ptr_req_val_o = 1'b1;
      StPtrResp: begin
        ptr_resp_rdy_o = 1'b1;
        latch_ptr_o    = ptr_resp_val_i;
      end
      StWrReq:   wr_req_val_o  = 1'b1;
      StWrData:  wr_data_val_o = 1'b1;
      StWrDone:  done_rdy_o    = 1'b1;
      StPtrAdj: begin
        ptr_req_val_o = 1'b1;
        adj_sel_o     = 1'b1;
        sent_set_o    = ptr_req_rdy_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/setup_confirm_tx_datap.sv
// Confirm datapath: latched flowid / head pointer and the outgoing flit builders.
module setup_confirm_tx_datap
  import setup_open_loop_pkg::*;
#(
  parameter int SRC_X = -1,
  parameter int SRC_Y = -1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  send_q_struct                   cmd_data_i,
  input  logic [NOC_DATA_WIDTH-1:0]      resp_data_i,
  input  logic                           latch_flowid_i,
  input  logic                           latch_ptr_i,
  input  logic                           adj_sel_i,
  input  logic                           sent_set_i,
  output logic                           cmd_is_resp_o,
  output logic                           resp_len_ok_o,
  output logic [NOC_DATA_WIDTH-1:0]      ptr_flit_o,
  output logic [FLOWID_W-1:0]            wr_req_flowid_o,
  output logic [TX_PAYLOAD_PTR_W-1:0]    wr_req_offset_o,
  output logic [MSG_DATA_SIZE_WIDTH-1:0] wr_req_size_o,
  output logic [NOC_DATA_WIDTH-1:0]      wr_data_o,
  output logic                           sent_val_o,
  output logic [FLOWID_W-1:0]            sent_flowid_o
);

  logic [FLOWID_W-1:0]      flowid_q;
  logic [PAYLOAD_PTR_W-1:0] head_ptr_q;
  logic                     sent_q;
  ptr_flit_t                resp;
  ptr_flit_t                ptr_flit;
  logic                     unused_resp;

  assign resp        = resp_data_i;
  assign unused_resp = ^{resp.hdr, resp.pad, resp.inner.flowid};

  assign cmd_is_resp_o = (cmd_data_i.cmd == CTRL_RESP);
  assign resp_len_ok_o = (resp.inner.length >= MSG_DATA_SIZE_WIDTH'(CONFIRM_BYTES));

  always_ff @(posedge clk) begin
    if (rst) begin
      flowid_q   <= '0;
      head_ptr_q <= '0;
      sent_q     <= 1'b0;
    end else begin
      if (latch_flowid_i) flowid_q <= cmd_data_i.flowid;
      if (latch_ptr_i) head_ptr_q <= resp.inner.head_ptr;
      sent_q <= sent_set_i;
    end
  end

  // Request and adjust share one flit shape; adjust carries the advanced pointer.
  always_comb begin
    ptr_flit                = '0;
    ptr_flit.hdr.dst_x      = TCP_TX_TILE_X;
    ptr_flit.hdr.dst_y      = TCP_TX_TILE_Y;
    ptr_flit.hdr.dst_fbits  = TCP_TX_APP_PTR_IF_FBITS;
    ptr_flit.hdr.msg_len    = '0;
    ptr_flit.hdr.msg_type   = adj_sel_i ? TCP_TX_ADJUST_PTR : TCP_TX_MSG_REQ;
    ptr_flit.hdr.src_x      = XY_W'(SRC_X);
    ptr_flit.hdr.src_y      = XY_W'(SRC_Y);
    ptr_flit.hdr.src_fbits  = SETUP_IF_FBITS;
    ptr_flit.inner.flowid   = flowid_q;
    ptr_flit.inner.length   = MSG_DATA_SIZE_WIDTH'(CONFIRM_BYTES);
    ptr_flit.inner.head_ptr = adj_sel_i ? head_ptr_q + PAYLOAD_PTR_W'(CONFIRM_BYTES) : '0;
  end

  assign ptr_flit_o      = ptr_flit;
  assign wr_req_flowid_o = flowid_q;
  // Write buffer handles ring wrap, so only the low offset bits are sent.
  assign wr_req_offset_o = head_ptr_q[TX_PAYLOAD_PTR_W-1:0];
  assign wr_req_size_o   = MSG_DATA_SIZE_WIDTH'(CONFIRM_BYTES);
  assign wr_data_o       = {flowid_q, {(NOC_DATA_WIDTH - FLOWID_W){1'b0}}};
  assign sent_val_o      = sent_q;
  assign sent_flowid_o   = flowid_q;

endmodule

// File: rtl/setup_confirm_tx.sv
// Sends a connection-setup confirm into a flow's TCP TX buffer, one command at a time.
module setup_confirm_tx
  import setup_open_loop_pkg::*;
#(
  parameter int SRC_X = -1,
  parameter int SRC_Y = -1
) (
  input  logic                           clk,
  input  logic                           rst,

  input  logic                           cmd_q_val,
  input  send_q_struct                   cmd_q_data,
  output logic                           cmd_q_rdy,

  output logic                           confirm_ptr_noc_val,
  output logic [NOC_DATA_WIDTH-1:0]      confirm_ptr_noc_data,
  input  logic                           ptr_noc_confirm_rdy,

  input  logic                           ptr_noc_confirm_val,
  input  logic [NOC_DATA_WIDTH-1:0]      ptr_noc_confirm_data,
  output logic                           confirm_ptr_noc_rdy,

  output logic                           confirm_wr_buf_req_val,
  output logic [FLOWID_W-1:0]            confirm_wr_buf_req_flowid,
  output logic [TX_PAYLOAD_PTR_W-1:0]    confirm_wr_buf_req_offset,
  output logic [MSG_DATA_SIZE_WIDTH-1:0] confirm_wr_buf_req_size,
  input  logic                           wr_buf_confirm_req_rdy,

  output logic                           confirm_wr_buf_data_val,
  output logic [NOC_DATA_WIDTH-1:0]      confirm_wr_buf_data,
  input  logic                           wr_buf_confirm_data_rdy,
  input  logic                           wr_buf_confirm_done_val,
  output logic                           confirm_wr_buf_done_rdy,

  output logic                           confirm_sent_val,
  output logic [FLOWID_W-1:0]            confirm_sent_flowid
);

  logic cmd_is_resp;
  logic resp_len_ok;
  logic latch_flowid;
  logic latch_ptr;
  logic adj_sel;
  logic sent_set;

  setup_confirm_tx_ctrl u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .cmd_val_i      (cmd_q_val),
    .cmd_is_resp_i  (cmd_is_resp),
    .ptr_req_rdy_i  (ptr_noc_confirm_rdy),
    .ptr_resp_val_i (ptr_noc_confirm_val),
    .resp_len_ok_i  (resp_len_ok),
    .wr_req_rdy_i   (wr_buf_confirm_req_rdy),
    .wr_data_rdy_i  (wr_buf_confirm_data_rdy),
    .done_val_i     (wr_buf_confirm_done_val),
    .cmd_rdy_o      (cmd_q_rdy),
    .ptr_req_val_o  (confirm_ptr_noc_val),
    .ptr_resp_rdy_o (confirm_ptr_noc_rdy),
    .wr_req_val_o   (confirm_wr_buf_req_val),
    .wr_data_val_o  (confirm_wr_buf_data_val),
    .done_rdy_o     (confirm_wr_buf_done_rdy),
    .latch_flowid_o (latch_flowid),
    .latch_ptr_o    (latch_ptr),
    .adj_sel_o      (adj_sel),
    .sent_set_o     (sent_set)
  );

  setup_confirm_tx_datap #(
    .SRC_X (SRC_X),
    .SRC_Y (SRC_Y)
  ) u_datap (
    .clk             (clk),
    .rst             (rst),
    .cmd_data_i      (cmd_q_data),
    .resp_data_i     (ptr_noc_confirm_data),
    .latch_flowid_i  (latch_flowid),
    .latch_ptr_i     (latch_ptr),
    .adj_sel_i       (adj_sel),
    .sent_set_i      (sent_set),
    .cmd_is_resp_o   (cmd_is_resp),
    .resp_len_ok_o   (resp_len_ok),
    .ptr_flit_o      (confirm_ptr_noc_data),
    .wr_req_flowid_o (confirm_wr_buf_req_flowid),
    .wr_req_offset_o (confirm_wr_buf_req_offset),
    .wr_req_size_o   (confirm_wr_buf_req_size),
    .wr_data_o       (confirm_wr_buf_data),
    .sent_val_o      (confirm_sent_val),
    .sent_flowid_o   (confirm_sent_flowid)
  );

endmodule

// File: tb/tb_setup_confirm_tx.sv
// Directed bench for setup_confirm_tx: full confirm, length retry, BENCH drop,
// per-state back-pressure, pointer wrap and mid-transaction reset.
module tb_setup_confirm_tx;
  import setup_open_loop_pkg::*;

  localparam int TB_SRC_X = 3;
  localparam int TB_SRC_Y = 2;
  localparam int W        = NOC_DATA_WIDTH;

  logic                           clk = 1'b0;
  logic                           rst;
  logic                           cmd_q_val;
  send_q_struct                   cmd_q_data;
  logic                           cmd_q_rdy;
  logic                           confirm_ptr_noc_val;
  logic [W-1:0]                   confirm_ptr_noc_data;
  logic                           ptr_noc_confirm_rdy;
  logic                           ptr_noc_confirm_val;
  logic [W-1:0]                   ptr_noc_confirm_data;
  logic                           confirm_ptr_noc_rdy;
  logic                           confirm_wr_buf_req_val;
  logic [FLOWID_W-1:0]            confirm_wr_buf_req_flowid;
  logic [TX_PAYLOAD_PTR_W-1:0]    confirm_wr_buf_req_offset;
  logic [MSG_DATA_SIZE_WIDTH-1:0] confirm_wr_buf_req_size;
  logic                           wr_buf_confirm_req_rdy;
  logic                           confirm_wr_buf_data_val;
  logic [W-1:0]                   confirm_wr_buf_data;
  logic                           wr_buf_confirm_data_rdy;
  logic                           wr_buf_confirm_done_val;
  logic                           confirm_wr_buf_done_rdy;
  logic                           confirm_sent_val;
  logic [FLOWID_W-1:0]            confirm_sent_flowid;

  int n_checks = 0;
  int n_fail   = 0;

  int req_cnt = 0, adj_cnt = 0, wr_cnt = 0, data_cnt = 0, sent_cnt = 0, val_cycles = 0;
  logic [W-1:0]        last_req, last_adj, last_wr, last_data;
  logic [FLOWID_W-1:0] last_sent_flow;

  always #5 clk = ~clk;

  setup_confirm_tx #(
    .SRC_X (TB_SRC_X),
    .SRC_Y (TB_SRC_Y)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .cmd_q_val                 (cmd_q_val),
    .cmd_q_data                (cmd_q_data),
    .cmd_q_rdy                 (cmd_q_rdy),
    .confirm_ptr_noc_val       (confirm_ptr_noc_val),
    .confirm_ptr_noc_data      (confirm_ptr_noc_data),
    .ptr_noc_confirm_rdy       (ptr_noc_confirm_rdy),
    .ptr_noc_confirm_val       (ptr_noc_confirm_val),
    .ptr_noc_confirm_data      (ptr_noc_confirm_data),
    .confirm_ptr_noc_rdy       (confirm_ptr_noc_rdy),
    .confirm_wr_buf_req_val    (confirm_wr_buf_req_val),
    .confirm_wr_buf_req_flowid (confirm_wr_buf_req_flowid),
    .confirm_wr_buf_req_offset (confirm_wr_buf_req_offset),
    .confirm_wr_buf_req_size   (confirm_wr_buf_req_size),
    .wr_buf_confirm_req_rdy    (wr_buf_confirm_req_rdy),
    .confirm_wr_buf_data_val   (confirm_wr_buf_data_val),
    .confirm_wr_buf_data       (confirm_wr_buf_data),
    .wr_buf_confirm_data_rdy   (wr_buf_confirm_data_rdy),
    .wr_buf_confirm_done_val   (wr_buf_confirm_done_val),
    .confirm_wr_buf_done_rdy   (confirm_wr_buf_done_rdy),
    .confirm_sent_val          (confirm_sent_val),
    .confirm_sent_flowid       (confirm_sent_flowid)
  );

  function automatic logic [MSG_TYPE_W-1:0] msg_type_of(input logic [W-1:0] d);
    ptr_flit_t f;
    f = d;
    return f.hdr.msg_type;
  endfunction

  function automatic logic [W-1:0] wr_req_pack();
    return W'({confirm_wr_buf_req_flowid, confirm_wr_buf_req_offset, confirm_wr_buf_req_size});
  endfunction

  // Handshake monitor: counts transfers and keeps the last payload of each kind.
  always @(posedge clk) begin
    if (confirm_ptr_noc_val && ptr_noc_confirm_rdy) begin
      if (msg_type_of(confirm_ptr_noc_data) == TCP_TX_MSG_REQ) begin
        req_cnt  <= req_cnt + 1;
        last_req <= confirm_ptr_noc_data;
      end else begin
        adj_cnt  <= adj_cnt + 1;
        last_adj <= confirm_ptr_noc_data;
      end
    end
    if (confirm_wr_buf_req_val && wr_buf_confirm_req_rdy) begin
      wr_cnt  <= wr_cnt + 1;
      last_wr <= wr_req_pack();
    end
    if (confirm_wr_buf_data_val && wr_buf_confirm_data_rdy) begin
      data_cnt  <= data_cnt + 1;
      last_data <= confirm_wr_buf_data;
    end
    if (confirm_sent_val) begin
      sent_cnt       <= sent_cnt + 1;
      last_sent_flow <= confirm_sent_flowid;
    end
    if (confirm_ptr_noc_val || confirm_wr_buf_req_val || confirm_wr_buf_data_val ||
        confirm_sent_val) begin
      val_cycles <= val_cycles + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_ptr_flit(input logic [MSG_TYPE_W-1:0] mt,
                                                input logic [FLOWID_W-1:0] fid,
                                                input logic [PAYLOAD_PTR_W-1:0] hp);
    ptr_flit_t f;
    f                = '0;
    f.hdr.dst_x      = 8'd1;
    f.hdr.dst_y      = 8'd0;
    f.hdr.dst_fbits  = 4'd2;
    f.hdr.msg_type   = mt;
    f.hdr.src_x      = 8'd3;
    f.hdr.src_y      = 8'd2;
    f.hdr.src_fbits  = 4'd3;
    f.inner.flowid   = fid;
    f.inner.length   = 16'd8;
    f.inner.head_ptr = hp;
    return f;
  endfunction

  function automatic logic [W-1:0] exp_wr(input logic [7:0] fid, input logic [11:0] off);
    return W'({fid, off, 16'd8});
  endfunction

  function automatic logic sig(input int sel);
    case (sel)
      0: return confirm_ptr_noc_val;
      1: return confirm_ptr_noc_rdy;
      2: return confirm_wr_buf_req_val;
      3: return confirm_wr_buf_data_val;
      4: return confirm_wr_buf_done_rdy;
      default: return confirm_sent_val;
    endcase
  endfunction

  function automatic logic [W-1:0] dat(input int sel);
    case (sel)
      0: return confirm_ptr_noc_data;
      2: return wr_req_pack();
      3: return confirm_wr_buf_data;
      default: return '0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sel(input string tag, input int sel);
    int n = 0;
    while (!sig(sel) && n < 100) begin
      step();
      n++;
    end
    if (!sig(sel)) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  // Ten stalled cycles: the selected signal must stay high with unchanged payload.
  task automatic hold10(input string tag, input int sel, input logic [W-1:0] exp);
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!sig(sel) || dat(sel) !== exp) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  task automatic send_cmd(input logic [1:0] c, input logic [FLOWID_W-1:0] fid);
    cmd_q_val  = 1'b1;
    cmd_q_data = '{cmd: c, flowid: fid};
    step();
    cmd_q_val  = 1'b0;
  endtask

  task automatic drive_resp(input logic [15:0] len, input logic [PAYLOAD_PTR_W-1:0] hp);
    ptr_flit_t f;
    wait_sel("resp_wait", 1);
    f                    = '0;
    f.inner.length       = len;
    f.inner.head_ptr     = hp;
    ptr_noc_confirm_data = f;
    ptr_noc_confirm_val  = 1'b1;
    step();
    ptr_noc_confirm_val  = 1'b0;
  endtask

  task automatic run_txn(input logic [FLOWID_W-1:0] fid, input bit retry,
                         input logic [PAYLOAD_PTR_W-1:0] hp);
    send_cmd(CTRL_RESP, fid);
    if (retry) drive_resp(16'd0, hp);
    drive_resp(16'd64, hp);
    wait_sel("sent_wait", 5);
    step();
  endtask

  initial begin
    int s_req, s_adj, s_wr, s_data, s_sent, s_val;
    rst                     = 1'b1;
    cmd_q_val               = 1'b0;
    cmd_q_data              = '0;
    ptr_noc_confirm_rdy     = 1'b0;
    ptr_noc_confirm_val     = 1'b0;
    ptr_noc_confirm_data    = '0;
    wr_buf_confirm_req_rdy  = 1'b0;
    wr_buf_confirm_data_rdy = 1'b0;
    wr_buf_confirm_done_val = 1'b0;
    step();
    step();
    rst = 1'b0;

    check_eq("rst_cmd_rdy", cmd_q_rdy, 1);
    check_eq("rst_ptr_val", confirm_ptr_noc_val, 0);
    check_eq("rst_resp_rdy", confirm_ptr_noc_rdy, 0);
    check_eq("rst_wr_req_val", confirm_wr_buf_req_val, 0);
    check_eq("rst_wr_data_val", confirm_wr_buf_data_val, 0);
    check_eq("rst_done_rdy", confirm_wr_buf_done_rdy, 0);
    check_eq("rst_sent_val", confirm_sent_val, 0);

    ptr_noc_confirm_rdy     = 1'b1;
    wr_buf_confirm_req_rdy  = 1'b1;
    wr_buf_confirm_data_rdy = 1'b1;
    wr_buf_confirm_done_val = 1'b1;

    // Basic confirm: flowid 5, head_ptr 0x10.
    s_req = req_cnt; s_adj = adj_cnt; s_wr = wr_cnt; s_data = data_cnt; s_sent = sent_cnt;
    run_txn(8'd5, 1'b0, 13'h010);
    check_eq("basic_req_cnt", req_cnt - s_req, 1);
    check_eq("basic_req_flit", last_req, exp_ptr_flit(TCP_TX_MSG_REQ, 8'd5, 13'h0));
    check_eq("basic_wr_cnt", wr_cnt - s_wr, 1);
    check_eq("basic_wr_req", last_wr, exp_wr(8'd5, 12'h010));
    check_eq("basic_data_cnt", data_cnt - s_data, 1);
    check_eq("basic_wr_data", last_data, {8'd5, 248'd0});
    check_eq("basic_adj_cnt", adj_cnt - s_adj, 1);
    check_eq("basic_adj_flit", last_adj, exp_ptr_flit(TCP_TX_ADJUST_PTR, 8'd5, 13'h018));
    check_eq("basic_sent_cnt", sent_cnt - s_sent, 1);
    check_eq("basic_sent_flow", last_sent_flow, 8'd5);

    // Short response forces one retry of the pointer request.
    s_req = req_cnt; s_adj = adj_cnt; s_wr = wr_cnt; s_sent = sent_cnt;
    run_txn(8'd9, 1'b1, 13'h020);
    check_eq("retry_req_cnt", req_cnt - s_req, 2);
    check_eq("retry_wr_cnt", wr_cnt - s_wr, 1);
    check_eq("retry_adj_cnt", adj_cnt - s_adj, 1);
    check_eq("retry_adj_flit", last_adj, exp_ptr_flit(TCP_TX_ADJUST_PTR, 8'd9, 13'h028));
    check_eq("retry_sent_cnt", sent_cnt - s_sent, 1);

    // BENCH command is swallowed without any traffic.
    s_val = val_cycles;
    send_cmd(BENCH, 8'd11);
    check_eq("bench_cmd_rdy", cmd_q_rdy, 1);
    repeat (5) step();
    check_eq("bench_no_traffic", val_cycles - s_val, 0);

    // Back-pressure in every handshake state.
    ptr_noc_confirm_rdy     = 1'b0;
    wr_buf_confirm_req_rdy  = 1'b0;
    wr_buf_confirm_data_rdy = 1'b0;
    wr_buf_confirm_done_val = 1'b0;
    s_sent = sent_cnt;
    send_cmd(CTRL_RESP, 8'd3);
    hold10("stall_ptr_req", 0, exp_ptr_flit(TCP_TX_MSG_REQ, 8'd3, 13'h0));
    ptr_noc_confirm_rdy = 1'b1;
    step();
    hold10("stall_ptr_resp", 1, '0);
    drive_resp(16'd64, 13'h040);
    ptr_noc_confirm_rdy = 1'b0;
    hold10("stall_wr_req", 2, exp_wr(8'd3, 12'h040));
    wr_buf_confirm_req_rdy = 1'b1;
    step();
    hold10("stall_wr_data", 3, {8'd3, 248'd0});
    wr_buf_confirm_data_rdy = 1'b1;
    step();
    hold10("stall_wr_done", 4, '0);
    wr_buf_confirm_done_val = 1'b1;
    step();
    hold10("stall_ptr_adj", 0, exp_ptr_flit(TCP_TX_ADJUST_PTR, 8'd3, 13'h048));
    check_eq("stall_no_early_sent", sent_cnt - s_sent, 0);
    ptr_noc_confirm_rdy = 1'b1;
    wait_sel("stall_sent_wait", 5);
    step();
    check_eq("stall_sent_cnt", sent_cnt - s_sent, 1);

    // Head pointer near the end of the pointer space wraps on adjust.
    run_txn(8'd7, 1'b0, 13'h1FFE);
    check_eq("wrap_wr_req", last_wr, exp_wr(8'd7, 12'hFFE));
    check_eq("wrap_adj_flit", last_adj, exp_ptr_flit(TCP_TX_ADJUST_PTR, 8'd7, 13'h0006));
    check_eq("wrap_sent_flow", last_sent_flow, 8'd7);

    // Reset while the data flit is stalled abandons the transaction.
    wr_buf_confirm_data_rdy = 1'b0;
    s_sent = sent_cnt; s_data = data_cnt;
    send_cmd(CTRL_RESP, 8'd4);
    drive_resp(16'd64, 13'h080);
    wait_sel("mid_rst_wait", 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_cmd_rdy", cmd_q_rdy, 1);
    check_eq("mid_rst_ptr_val", confirm_ptr_noc_val, 0);
    check_eq("mid_rst_wr_req_val", confirm_wr_buf_req_val, 0);
    check_eq("mid_rst_wr_data_val", confirm_wr_buf_data_val, 0);
    check_eq("mid_rst_sent_val", confirm_sent_val, 0);
    repeat (5) step();
    check_eq("mid_rst_no_sent", sent_cnt - s_sent, 0);
    check_eq("mid_rst_no_data", data_cnt - s_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
